cache_array_bmask: RTL and testbench

Parametrised, byte-maskable storage array for the cache datapath, serving data, tag, valid and dirty arrays from one module. It has:

- one write port and two independent combinational read ports;
- per-entry valid bits;
- write-to-read bypass that respects the byte mask;
- a sequential clear engine that invalidates the whole array one entry per cycle, used for cache flush/invalidate without a global reset.

It sits beside the cache control FSM, which drives the index, load and clear controls.

---
 rtl/cache_array_bmask.sv | 141 ++++++++++++++
 tb/tb_cache_array_bmask.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_array_bmask.sv
// Byte-maskable storage array with two combinational read ports, per-entry
// valid bits, mask-aware write bypass and a one-entry-per-cycle clear engine.
module cache_array_bmask #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [WIDTH/8-1:0]       wmask,
    input  logic [$clog2(DEPTH)-1:0] windex,
    input  logic [WIDTH-1:0]         datain,
    input  logic [$clog2(DEPTH)-1:0] rindex0,
    input  logic [$clog2(DEPTH)-1:0] rindex1,
    output logic [WIDTH-1:0]         dataout0,
    output logic [WIDTH-1:0]         dataout1,
    output logic                     valid0,
    output logic                     valid1,
    input  logic                     clear,
    output logic                     busy,
    output logic                     clear_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned NB    = WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                        state;
    state_t                        state_n;
    logic [IDX_W-1:0]              ptr;
    logic [IDX_W-1:0]              ptr_n;
    logic                          done_n;
    logic [DEPTH-1:0][WIDTH-1:0]   mem;
    logic [DEPTH-1:0]              valid;
    logic                          wr_en;
    logic                          clr_en;
    logic                          byp0;
    logic                          byp1;
    logic [WIDTH-1:0]              merged;

    // State register, clear pointer and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            clear_done <= done_n;
        end
    end

    // Next-state logic: walk the pointer through every entry once
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                end
            end
            CLEAR: begin
                if (ptr == IDX_W'(DEPTH - 1)) begin
                    state_n = IDLE;
                    ptr_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    ptr_n = ptr + IDX_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
            end
        endcase
    end

    // Output decode; clear takes priority over a same-cycle load
    always_comb begin
        busy   = 1'b0;
        wr_en  = 1'b0;
        clr_en = 1'b0;
        byp0   = 1'b0;
        byp1   = 1'b0;
        case (state)
            IDLE: begin
                wr_en = load && !clear;
                byp0  = load && (rindex0 == windex);
                byp1  = load && (rindex1 == windex);
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Byte-merge of incoming data over the currently stored entry
    always_comb begin
        merged = mem[windex];
        for (int b = 0; b < int'(NB); b++) begin
            if (wmask[b]) begin
                merged[8*b +: 8] = datain[8*b +: 8];
            end
        end
    end

    // Storage and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem   <= '0;
            valid <= '0;
        end else if (clr_en) begin
            mem[ptr]   <= '0;
            valid[ptr] <= 1'b0;
        end else if (wr_en) begin
            mem[windex]   <= merged;
            valid[windex] <= 1'b1;
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        dataout0 = byp0 ? merged : mem[rindex0];
        dataout1 = byp1 ? merged : mem[rindex1];
        valid0   = byp0 | valid[rindex0];
        valid1   = byp1 | valid[rindex1];
    end

endmodule

// File: tb/tb_cache_array_bmask.sv
// Bench for cache_array_bmask: vector table plus clear/reset sequences, with
// expected outputs queued on drive and popped when the outputs are sampled.
module tb_cache_array_bmask;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic        load;
        logic [3:0]  wmask;
        logic [2:0]  windex;
        logic [31:0] datain;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic        clear;
        logic [31:0] d0;
        logic        v0;
        logic [31:0] d1;
        logic        v1;
        logic        busy;
        logic        done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  wmask = '0;
    logic [2:0]  windex = '0;
    logic [31:0] datain = '0;
    logic [2:0]  rindex0 = '0;
    logic [2:0]  rindex1 = '0;
    logic        clear = 1'b0;
    logic [31:0] dataout0;
    logic [31:0] dataout1;
    logic        valid0;
    logic        valid1;
    logic        busy;
    logic        clear_done;

    int checks = 0;
    int errors = 0;
    vec_t sbq[$];
    vec_t tbl[9];

    cache_array_bmask #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load(load), .wmask(wmask), .windex(windex),
        .datain(datain), .rindex0(rindex0), .rindex1(rindex1),
        .dataout0(dataout0), .dataout1(dataout1), .valid0(valid0),
        .valid1(valid1), .clear(clear), .busy(busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic [3:0] m, input logic [2:0] wi,
                                input logic [31:0] di, input logic [2:0] a0, input logic [2:0] a1,
                                input logic cl, input logic [31:0] e0, input logic ev0,
                                input logic [31:0] e1, input logic ev1, input logic eb,
                                input logic ed);
        vec_t v;
        v.load = ld; v.wmask = m; v.windex = wi; v.datain = di;
        v.r0 = a0; v.r1 = a1; v.clear = cl;
        v.d0 = e0; v.v0 = ev0; v.d1 = e1; v.v1 = ev1; v.busy = eb; v.done = ed;
        return v;
    endfunction

    function automatic logic [31:0] fv(input int k);
        return 32'h10203040 + 32'(k) * 32'h01010101;
    endfunction

    task automatic drive(input vec_t v);
        load = v.load; wmask = v.wmask; windex = v.windex; datain = v.datain;
        rindex0 = v.r0; rindex1 = v.r1; clear = v.clear;
        sbq.push_back(v);
    endtask

    // Compare at the falling edge, then advance to just after the next rising edge
    task automatic sample(input string tag);
        vec_t e;
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".d0"}, dataout0, e.d0);
            chk({tag, ".v0"}, 32'(valid0), 32'(e.v0));
            chk({tag, ".d1"}, dataout1, e.d1);
            chk({tag, ".v1"}, 32'(valid1), 32'(e.v1));
            chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
            chk({tag, ".done"}, 32'(clear_done), 32'(e.done));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string tag);
        drive(v);
        sample(tag);
    endtask

    initial begin
        tbl[0] = mk(1, 4'hF, 3, 32'hAABBCCDD, 3, 2, 0, 32'hAABBCCDD, 1, 32'h0, 0, 0, 0);
        tbl[1] = mk(1, 4'h5, 3, 32'h11223344, 3, 3, 0, 32'hAA22CC44, 1, 32'hAA22CC44, 1, 0, 0);
        tbl[2] = mk(0, 4'h0, 0, 32'h0,        3, 0, 0, 32'hAA22CC44, 1, 32'h0, 0, 0, 0);
        tbl[3] = mk(1, 4'h0, 5, 32'h12345678, 5, 5, 0, 32'h0, 1, 32'h0, 1, 0, 0);
        tbl[4] = mk(1, 4'hF, 4, 32'hCAFEF00D, 4, 5, 0, 32'hCAFEF00D, 1, 32'h0, 1, 0, 0);
        tbl[5] = mk(1, 4'h2, 5, 32'hFFFFFFFF, 5, 5, 0, 32'h0000FF00, 1, 32'h0000FF00, 1, 0, 0);
        tbl[6] = mk(1, 4'h2, 5, 32'hFFFFFFFF, 5, 4, 0, 32'h0000FF00, 1, 32'hCAFEF00D, 1, 0, 0);
        tbl[7] = mk(0, 4'h0, 0, 32'h0,        5, 4, 0, 32'h0000FF00, 1, 32'hCAFEF00D, 1, 0, 0);
        tbl[8] = mk(0, 4'h0, 0, 32'h0,        7, 6, 0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst.d0", dataout0, 32'h0);
        chk("rst.d1", dataout1, 32'h0);
        chk("rst.v0", 32'(valid0), 32'h0);
        chk("rst.v1", 32'(valid1), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(clear_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Fill every entry, then clear with a colliding load on the issue cycle
        for (int k = 0; k < 8; k++)
            step(mk(1, 4'hF, 3'(k), fv(k), 3'(k), 3'(k), 0, fv(k), 1, fv(k), 1, 0, 0),
                 $sformatf("fill%0d", k));
        step(mk(1, 4'hF, 2, 32'hDEADBEEF, 0, 1, 1, fv(0), 1, fv(1), 1, 0, 0), "clr_issue");
        for (int c = 0; c < 8; c++) begin
            if (c == 0)
                step(mk(1, 4'hF, 3'(c), 32'hFFFFFFFF, 3'(c), 3'd7, 0, fv(c), 1, fv(7), 1, 1, 0),
                     $sformatf("clr_busy%0d", c));
            else
                step(mk(1, 4'hF, 3'(c), 32'hFFFFFFFF, 3'(c), 3'(c - 1), 0, fv(c), 1, 32'h0, 0, 1, 0),
                     $sformatf("clr_busy%0d", c));
        end
        step(mk(1, 4'hF, 2, 32'h55AA55AA, 2, 3, 0, 32'h55AA55AA, 1, 32'h0, 0, 0, 1), "clr_done");
        step(mk(0, 4'h0, 0, 32'h0, 2, 7, 0, 32'h55AA55AA, 1, 32'h0, 0, 0, 0), "post_clr");
        for (int k = 0; k < 8; k += 2)
            step(mk(0, 4'h0, 0, 32'h0, 3'(k), 3'(k + 1), 0,
                    (k == 2) ? 32'h55AA55AA : 32'h0, (k == 2) ? 1'b1 : 1'b0, 32'h0, 0, 0, 0),
                 $sformatf("post_rd%0d", k));

        // Clear held high restarts one cycle after clear_done
        for (int i = 0; i < 20; i++)
            step(mk(0, 4'h0, 0, 32'h0, 0, 0, (i <= 9) ? 1'b1 : 1'b0, 32'h0, 0, 32'h0, 0,
                    (i == 0 || i == 9 || i >= 18) ? 1'b0 : 1'b1,
                    (i == 9 || i == 18) ? 1'b1 : 1'b0),
                 $sformatf("b2b%0d", i));

        // Reset in the middle of a clear
        step(mk(1, 4'hF, 1, 32'h01234567, 1, 0, 0, 32'h01234567, 1, 32'h0, 0, 0, 0), "rmc_wr");
        step(mk(0, 4'h0, 0, 32'h0, 1, 0, 1, 32'h01234567, 1, 32'h0, 0, 0, 0), "rmc_issue");
        step(mk(0, 4'h0, 0, 32'h0, 1, 0, 0, 32'h01234567, 1, 32'h0, 0, 1, 0), "rmc_busy0");
        step(mk(0, 4'h0, 0, 32'h0, 1, 0, 0, 32'h01234567, 1, 32'h0, 0, 1, 0), "rmc_busy1");
        step(mk(0, 4'h0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0), "rmc_busy2");
        rindex0 = 3'd1;
        rindex1 = 3'd0;
        chk("rmc_pre.busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rmc_rst.busy", 32'(busy), 32'h0);
        chk("rmc_rst.done", 32'(clear_done), 32'h0);
        chk("rmc_rst.d0", dataout0, 32'h0);
        chk("rmc_rst.v0", 32'(valid0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++)
            step(mk(0, 4'h0, 0, 32'h0, 3'(i), 3'(i + 4), 0, 32'h0, 0, 32'h0, 0, 0, 0),
                 $sformatf("rmc_idle%0d", i));
        step(mk(1, 4'hC, 6, 32'h0BADF00D, 6, 6, 0, 32'h0BAD0000, 1, 32'h0BAD0000, 1, 0, 0), "rmc_wr6");
        step(mk(0, 4'h0, 0, 32'h0, 6, 5, 0, 32'h0BAD0000, 1, 32'h0, 0, 0, 0), "rmc_rd6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
